add_result_stage: RTL and testbench
===================================

// Module: add_result_stage
// PURPOSE
//   Registered output stage directly downstream of the WIDTH-bit full adder (fulladdR).
//   Captures {sum, cout} with a valid/ready handshake and derives zero/negative/signed-overflow flags.
//   A 2-entry skid buffer absorbs one cycle of consumer backpressure with no loss and no bubble.
//   Counts delivered results for debug.
// PARAMETERS
//   WIDTH    4   adder operand/sum width in bits
//   CNT_W    8   width of the delivered-result counter
// PORTS
//   clk          in   1      single clock; all state updates on posedge
//   reset        in   1      synchronous, active-high
//   in_valid     in   1      adder result presented this cycle
//   in_ready     out  1      stage can accept; transfer when in_valid & in_ready
//   in_sum       in   WIDTH  adder sum output (o)
//   in_cout      in   1      adder carry out
//   in_a_msb     in   1      MSB of operand i0, for overflow detection
//   in_b_msb     in   1      MSB of operand i1, for overflow detection
//   out_valid    out  1      registered result available
//   out_ready    in   1      consumer accepts; transfer when out_valid & out_ready
//   out_sum      out  WIDTH  registered sum
//   out_cout     out  1      registered carry
//   out_zero     out  1      out_sum == 0 (cout ignored)
//   out_neg      out  1      out_sum[WIDTH-1]
//   out_ovf      out  1      signed overflow: (a_msb == b_msb) && (sum[WIDTH-1] != a_msb)
//   out_count    out  CNT_W  number of output transfers since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset, checked on posedge clk: out_valid=0, in_ready=1, all out_* data/flags=0, out_count=0, skid empty.
//   - Flags are computed combinationally at the input and stored with the payload. The payload is
//     {sum, cout, zero, neg, ovf} = WIDTH+4 bits.
//   - Latency: an input accepted at edge N is visible on out_* after edge N (1 cycle) when the main register is free.
//   - Storage: main register (drives out_*) plus a skid register. in_ready = !skid_valid, taken from a flop
//     with no combinational path from out_ready.
//   - States (occupancy): EMPTY(0) / HALF(main only) / FULL(main + skid).
//       EMPTY: push         -> HALF.
//       HALF:  push & !pop  -> FULL (data goes to skid).
//       HALF:  pop & !push  -> EMPTY.
//       HALF:  push & pop   -> HALF (new data goes to main).
//       FULL:  pop          -> HALF (skid moves to main). No push is possible because in_ready=0.
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - Order is strictly preserved. Data is never dropped or duplicated.
//   - out_* hold stable while out_valid & !out_ready.
//   - in_valid while in_ready=0: the input is ignored. The upstream holds its data.
//   - out_count increments on each pop. 2^CNT_W-1 wraps to 0 with no flag.
//   - Reset asserted mid-transfer: all entries are discarded on that edge, and no pop is counted.
//   - Width rule: no extension. The sum is exactly WIDTH bits, and carry is reported separately.
// STRUCTURE
//   - Shared package add_pkg holds:
//       * the WIDTH default;
//       * PAYLOAD_W = WIDTH+4;
//       * the payload field offsets (SUM, COUT, ZERO, NEG, OVF);
//       * the occupancy encoding EMPTY=2'd0, HALF=2'd1, FULL=2'd2.
//   - One sub-module: result_skid_buf. It is a generic 2-entry valid/ready skid buffer parameterised by DATA_W.
//     The top level holds the flag logic, payload packing/unpacking and out_count.
// TESTING (WIDTH=4; clk period 10, inputs driven off-edge)
//   1. Reset held 2 cycles, then released -> out_valid=0, in_ready=1, out_count=0, all flags 0.
//   2. in_sum=4'b1000, cout=0, a_msb=0, b_msb=0 (0111+0001), out_ready=1 ->
//      next cycle out_sum=1000, neg=1, ovf=1, zero=0, out_count=1.
//   3. in_sum=4'b0000, cout=1, a_msb=1, b_msb=0 (1111+0001) ->
//      out_sum=0000, cout=1, zero=1, ovf=0, neg=0.
//   4. Backpressure: 3 back-to-back inputs (sum 1, 2, 3) with out_ready=0 for 3 cycles, then 1 ->
//      in_ready falls after the 2nd accept; the 3rd input is held by the source;
//      outputs arrive in order 1, 2, 3; out_count=3.
//   5. Streaming with in_valid=out_ready=1 for 20 cycles -> one result per cycle, in_ready never drops,
//      out_count=20.
//   6. Stage FULL, then reset pulsed for 1 cycle -> out_valid=0 and in_ready=1 on the next edge;
//      old data never appears; out_count=0.
//   Additionally: 256 pops with CNT_W=8 -> out_count wraps to 0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the adder result stage.
//   WIDTH_DEFAULT   default adder operand/sum width
//   payload_width() payload size for a given sum width: {sum, cout, zero, neg, ovf}
//   PAYLOAD_W       payload size at the default width
//   *_BIT / SUM_LSB bit positions of each field inside the payload word
//   occ_e           skid buffer occupancy encoding
package add_pkg;

  localparam int WIDTH_DEFAULT = 4;

  function automatic int payload_width(input int w);
    return w + 4;
  endfunction

  localparam int PAYLOAD_W = payload_width(WIDTH_DEFAULT);

  // Flags sit in the low bits so their offsets do not depend on WIDTH;
  // the sum occupies [SUM_LSB +: WIDTH].
  localparam int OVF_BIT  = 0;
  localparam int NEG_BIT  = 1;
  localparam int ZERO_BIT = 2;
  localparam int COUT_BIT = 3;
  localparam int SUM_LSB  = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,  // nothing held
    OCC_HALF  = 2'd1,  // main register only
    OCC_FULL  = 2'd2   // main register and skid register
  } occ_e;

endpackage

// File: rtl/result_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
//   clk, reset          clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and data
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and data
// out_data_o comes straight from the main register. in_ready_o is decoded
// from the occupancy flop only, so there is no combinational path from
// out_ready_i to in_ready_o.
module result_skid_buf
  import add_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push, pop;

  assign in_ready_o  = (occ_q != OCC_FULL);
  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign out_data_o  = main_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d  = OCC_HALF;
          main_d = in_data_i;
        end
      end
      OCC_HALF: begin
        if (push && !pop) begin
          // Consumer stalled: park the new item behind the main register.
          occ_d  = OCC_FULL;
          skid_d = in_data_i;
        end else if (pop && !push) begin
          occ_d = OCC_EMPTY;
        end else if (push && pop) begin
          main_d = in_data_i;
        end
      end
      OCC_FULL: begin
        // in_ready_o is low here, so a push cannot coincide with the pop.
        if (pop) begin
          occ_d  = OCC_HALF;
          main_d = skid_q;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      // NOTE: the data registers are reset too because they drive out_*
      // directly and must read zero after reset.
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/add_result_stage.sv
// Registered output stage downstream of a WIDTH-bit full adder.
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               upstream handshake
//   in_sum, in_cout                 adder sum and carry out
//   in_a_msb, in_b_msb              operand MSBs for signed overflow
//   out_valid/out_ready             downstream handshake
//   out_sum, out_cout               registered result
//   out_zero, out_neg, out_ovf      registered flags
//   out_count                       delivered results since reset (wraps)
// Flags are derived at the input and travel with the payload through the
// skid buffer, so they always match the sum they describe.
module add_result_stage
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam int PW = payload_width(WIDTH);

  logic [PW-1:0]    in_payload, out_payload;
  logic             in_zero, in_neg, in_ovf;
  logic [CNT_W-1:0] count_q, count_d;

  // Zero ignores the carry: 1111+0001 yields zero with cout=1.
  assign in_zero = (in_sum == '0);
  assign in_neg  = in_sum[WIDTH-1];
  // Signed overflow: operands agree in sign but the sum does not.
  assign in_ovf  = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);

  always_comb begin
    in_payload                     = '0;
    in_payload[SUM_LSB +: WIDTH]   = in_sum;
    in_payload[COUT_BIT]           = in_cout;
    in_payload[ZERO_BIT]           = in_zero;
    in_payload[NEG_BIT]            = in_neg;
    in_payload[OVF_BIT]            = in_ovf;
  end

  result_skid_buf #(
    .DATA_W (PW)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_payload),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_payload)
  );

  assign out_sum  = out_payload[SUM_LSB +: WIDTH];
  assign out_cout = out_payload[COUT_BIT];
  assign out_zero = out_payload[ZERO_BIT];
  assign out_neg  = out_payload[NEG_BIT];
  assign out_ovf  = out_payload[OVF_BIT];

  // Wraps silently at 2^CNT_W.
  assign count_d = (out_valid && out_ready) ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign out_count = count_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Self-checking bench for add_result_stage (WIDTH=4, CNT_W=8).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// A monitor pushes the expected payload when an input transfer is seen and
// pops/compares it when an output transfer is seen.
module tb_add_result_stage;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout, in_a_msb, in_b_msb;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout, out_zero, out_neg, out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  add_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference payload {sum, cout, zero, neg, ovf} built from the adder outputs.
  function automatic logic [7:0] model(input logic [3:0] s, input logic c, input logic a,
                                       input logic b);
    logic z, n, o;
    z = (s == 4'd0);
    n = s[3];
    o = (a == b) && (s[3] != a);
    return {s, c, z, n, o};
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_output", {24'd0, out_sum, out_cout, out_zero,
                                    out_neg, out_ovf}, 32'hFFFF_FFFF);
        else check("sb_payload", {24'd0, out_sum, out_cout, out_zero, out_neg, out_ovf},
                   {24'd0, sb_q.pop_front()});
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_sum, in_cout, in_a_msb, in_b_msb));
    end
  end

  // Present one input and hold it until accepted; returns cycles stalled.
  task automatic send(input logic [3:0] s, input logic c, input logic a, input logic b,
                      output int stalls);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sum = s; in_cout = c; in_a_msb = a; in_b_msb = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    stalls = n;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n, output int stalls);
    int st;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send(i[3:0], 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), st);
      stalls += st;
    end
    idle();
  endtask

  initial begin
    int st;
    reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
    in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b1;

    // 1. Reset held two cycles.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {24'd0, out_count}, 32'd0);
    check("rst_data", {24'd0, out_sum, out_cout, out_zero, out_neg, out_ovf}, 32'd0);

    // 2. 0111+0001 = 1000: negative, signed overflow, one-cycle latency.
    send(4'b1000, 1'b0, 1'b0, 1'b0, st);
    idle();
    @(negedge clk);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_sum", {28'd0, out_sum}, 32'h8);
    check("t2_flags", {29'd0, out_zero, out_neg, out_ovf}, 32'b011);
    @(negedge clk);
    check("t2_count", {24'd0, out_count}, 32'd1);

    // 3. 1111+0001 = 0000 carry 1: zero, no overflow.
    send(4'b0000, 1'b1, 1'b1, 1'b0, st);
    idle();
    @(negedge clk);
    check("t3_sum_cout", {27'd0, out_sum, out_cout}, 32'b00001);
    check("t3_flags", {29'd0, out_zero, out_neg, out_ovf}, 32'b100);
    @(negedge clk);
    check("t3_count", {24'd0, out_count}, 32'd2);

    // 4. Backpressure: three back-to-back inputs while the consumer stalls.
    out_ready = 1'b0;
    fork
      begin
        send(4'd1, 1'b0, 1'b0, 1'b0, st);
        send(4'd2, 1'b0, 1'b0, 1'b0, st);
        send(4'd3, 1'b0, 1'b0, 1'b0, st);
        check("t4_third_held", (st > 0) ? 32'd1 : 32'd0, 32'd1);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("t4_hold_sum", {27'd0, out_valid, out_sum}, 32'h11);
        @(negedge clk);
        check("t4_hold_stable", {27'd0, out_valid, out_sum}, 32'h11);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("t4_count", {24'd0, out_count}, 32'd5);

    // 5. Streaming at full rate.
    stream(20, st);
    repeat (3) @(negedge clk);
    check("t5_no_stall", st, 32'd0);
    check("t5_count", {24'd0, out_count}, 32'd25);

    // 6. Fill the stage, then pulse reset: contents are discarded.
    out_ready = 1'b0;
    send(4'd9, 1'b0, 1'b0, 1'b0, st);
    send(4'd10, 1'b0, 1'b0, 1'b0, st);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_count", {24'd0, out_count}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_stale", {31'd0, out_valid}, 32'd0);

    // Counter wrap at 2^CNT_W pops.
    stream(255, st);
    repeat (3) @(negedge clk);
    check("wrap_255", {24'd0, out_count}, 32'd255);
    stream(1, st);
    repeat (3) @(negedge clk);
    check("wrap_zero", {24'd0, out_count}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
